riscv_instenc: RTL
==================

// Module: riscv_instenc
// PURPOSE
//  Instruction encoder: the inverse of the immediate generator. Packs opcode, register, funct and
//  64-bit immediate fields into a 32-bit R/I/S/SB instruction, then streams it with a word address
//  to the instruction-memory write port. Used by the bench loader and the self-test program builder.
//  Input and output are valid/ready; a DEPTH-entry output FIFO absorbs backpressure.
// PARAMETERS
//  ADDR_W     32   width of addr_o
//  BASE_ADDR  0    first write address, also the value after flush_i
//  DEPTH      2    output FIFO entries (power of 2, >=2)
// PORTS
//  clk_i          in   1       clock; all state updates on the rising edge
//  rstn_i         in   1       reset, asynchronous, active-low
//  flush_i        in   1       sync clear of FIFO and address counter
//  valid_i        in   1       input fields valid
//  ready_o        out  1       encoder can accept input
//  fmt_i          in   2       00=R 01=I 10=S 11=SB
//  opcode_i       in   7       written to inst[6:0] as given
//  rd_i,rs1_i,rs2_i in 5 each  register fields
//  funct3_i       in   3       inst[14:12]
//  funct7_i       in   7       inst[31:25], R-format only
//  immediate_i    in   64      sign-extended immediate; SB in halfword units (imm[12:1])
//  valid_o        out  1       instruction_o/addr_o valid
//  ready_i        in   1       memory side accepts
//  instruction_o  out  32      encoded instruction
//  addr_o         out  ADDR_W  byte address of instruction_o
//  count_o        out  clog2(DEPTH)+1  FIFO occupancy
//  err_o          out  1       one-cycle pulse on a rejected immediate (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstn_i=0, any time, incl. mid-transfer): FIFO empty, valid_o=0, count_o=0, err_o=0,
//   instruction_o=0, addr_o=BASE_ADDR, wr address counter=BASE_ADDR; in-flight data discarded.
//  Accept when valid_i&&ready_o; ready_o = (count_o<DEPTH) || (valid_o&&ready_i) (same-cycle pop frees a slot).
//  Encoding (imm = immediate_i[11:0]):
//   R : {funct7,rs2,rs1,funct3,rd,opcode}
//   I : {imm[11:0],rs1,funct3,rd,opcode}
//   S : {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//   SB: {imm[11],imm[9:4],rs2,rs1,funct3,imm[3:0],imm[10],opcode}
//   Unused fields ignored (rd in S/SB, rs2/funct7 in I, funct7 in S/SB, immediate_i in R).
//  Latency: accepted fields appear on instruction_o no earlier than the next cycle (registered FIFO write).
//  addr_o: each enqueued entry is tagged with the counter value; counter += 4 per enqueue, wraps mod 2^ADDR_W.
//  Output: FIFO head is driven while valid_o=1; pop on valid_o&&ready_i; strict FIFO order; head stable while stalled.
//  Simultaneous push+pop when full: both happen; count unchanged.
//  flush_i: FIFO emptied, counter=BASE_ADDR; an input accepted in the same cycle is dropped; flush wins over push.
//  count_o increments on push only, decrements on pop only, and is unchanged on push+pop.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined: for I/S/SB, immediate_i[63:11] must all equal immediate_i[11].
//   Otherwise the input is still accepted (handshake completes) but is not enqueued; err_o=1 for one
//   cycle; counter unchanged.
//  Not defined: no check; bits [63:12] are silently truncated; err_o tied 0.
// TESTING
//  1 I: fmt=01 op=0010011 rd=1 rs1=0 f3=0 imm=5 -> 0x00500093 at addr 0x0, one cycle after accept.
//  2 S+R: SD rs2=2 rs1=3 f3=011 imm=8 -> 0x0021B423 @0x0; then ADD rd=3 rs1=1 rs2=2 -> 0x002081B3 @0x4.
//  3 SB: op=1100011 rs1=rs2=0 f3=0 imm=-2 (0xFFF..FFE) -> 0xFE000EE3; immgen decode of it returns -2.
//  4 Backpressure: ready_i=0, offer 3 inputs -> 2 enqueued, ready_o=0, third held; ready_i=1 -> order 0x0,0x4,0x8.
//  5 Range (macro on): I imm=2048 -> err_o pulses 1 cycle, nothing enqueued, next addr still 0x0.
//    Macro off: output is 0x80000093 (for rd=1).
//  6 Reset with 2 queued, and flush_i with push -> valid_o=0, count_o=0; next output at BASE_ADDR.

Source files
------------

// File: rtl/riscv_instenc.sv
// RISC-V R/I/S/SB instruction encoder streaming {instruction, byte address} through a small FIFO.
// Optional immediate range checking is enabled with `define ENC_RANGE_CHECK_EN.
module riscv_instenc #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          DEPTH     = 2
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [1:0]                 fmt_i,
    input  logic [6:0]                 opcode_i,
    input  logic [4:0]                 rd_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    input  logic [2:0]                 funct3_i,
    input  logic [6:0]                 funct7_i,
    input  logic [63:0]                immediate_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [31:0]                instruction_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        FmtR  = 2'b00,
        FmtI  = 2'b01,
        FmtS  = 2'b10,
        FmtSb = 2'b11
    } fmt_e;

    logic [31:0]       inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       enc_inst;
    logic [11:0]       imm;
    logic              imm_bad;
    logic              accept, push, pop;
    logic              unused_imm;

    assign imm        = immediate_i[11:0];
    assign unused_imm = ^immediate_i[63:12];

    always_comb begin
        enc_inst = '0;
        unique case (fmt_e'(fmt_i))
            FmtR:  enc_inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FmtI:  enc_inst = {imm[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FmtS:  enc_inst = {imm[11:5], rs2_i, rs1_i, funct3_i, imm[4:0], opcode_i};
            // SB immediate is in halfword units, so imm[0] here is branch offset bit 1
            FmtSb: enc_inst = {imm[11], imm[9:4], rs2_i, rs1_i, funct3_i, imm[3:0], imm[10],
                               opcode_i};
            default: enc_inst = '0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Immediate must be a sign-extended 12-bit value for every format that carries one
    assign imm_bad = (fmt_i != FmtR) &&
                     !((&immediate_i[63:11]) || (~|immediate_i[63:11]));
`else
    assign imm_bad = 1'b0;
`endif

    assign valid_o = (count_q != '0);
    assign ready_o = (count_q < DEPTH_CNT) || (valid_o && ready_i);
    assign accept  = valid_i && ready_o && !flush_i;
    assign push    = accept && !imm_bad;
    assign pop     = valid_o && ready_i && !flush_i;

    assign instruction_o = valid_o ? inst_mem_q[rd_ptr_q] : '0;
    assign addr_o        = valid_o ? addr_mem_q[rd_ptr_q] : BASE_ADDR;
    assign count_o       = count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                addr_mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_addr_q <= BASE_ADDR;
        end else if (flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_addr_q <= BASE_ADDR;
        end else begin
            if (push) begin
                inst_mem_q[wr_ptr_q] <= enc_inst;
                addr_mem_q[wr_ptr_q] <= wr_addr_q;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
                wr_addr_q            <= wr_addr_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && imm_bad;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
